// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings, FSM states
// and a helper that classifies which modes a burst may run.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode >= MODE_SHL) && (mode <= MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational next-word function for one shift/rotate step, shared by the single-step
// and burst paths. Zero latency; no flow control. LOAD is resolved by the caller.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin_msb,
    input  logic             i_sin_lsb,
    output logic [WIDTH-1:0] o_q
);

    always_comb begin
        o_q = i_d;
        case (i_mode)
            MODE_SHL: o_q = {i_d[WIDTH-2:0], i_sin_lsb};
            MODE_SHR: o_q = {i_sin_msb, i_d[WIDTH-1:1]};
            MODE_ROL: o_q = {i_d[WIDTH-2:0], i_d[WIDTH-1]};
            MODE_ROR: o_q = {i_d[0], i_d[WIDTH-1:1]};
            MODE_ASR: o_q = {i_d[WIDTH-1], i_d[WIDTH-1:1]};
            default:  o_q = i_d;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops and an autonomous N-step burst engine.
// Latency 1 edge per step; a burst of N runs N edges after acceptance, then pulses done.
// No backpressure: start/en are only honoured in IDLE, all controls are ignored while busy.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH+1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_d_in,
    input  logic             i_sin_msb,
    input  logic             i_sin_lsb,
    input  logic             i_start,
    input  logic [CW-1:0]    i_cnt,
    output logic [WIDTH-1:0] o_d_out,
    output logic             o_sout_msb,
    output logic             o_sout_lsb,
    output logic             o_busy,
    output logic             o_done
);

    import usr_pkg::*;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_rem, w_rem_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic             r_done, w_done_nxt;

    logic [2:0]       w_step_mode;
    logic [WIDTH-1:0] w_step_q;
    logic [CW-1:0]    w_cnt_clamp;
    logic             w_start_ok;

    // While running, the latched op drives the step function; live mode is ignored.
    assign w_step_mode = (r_state == ST_RUN) ? r_op : i_mode;
    assign w_cnt_clamp = (i_cnt > CNT_MAX) ? CNT_MAX : i_cnt;
    assign w_start_ok  = i_start && is_shift_mode(i_mode);

    usr_step #(.WIDTH(WIDTH)) u_step (
        .i_mode    (w_step_mode),
        .i_d       (r_data),
        .i_sin_msb (i_sin_msb),
        .i_sin_lsb (i_sin_lsb),
        .o_q       (w_step_q)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_op    <= MODE_HOLD;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    // A zero-length burst completes immediately without touching the word.
                    if (i_cnt == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_rem_nxt   = w_cnt_clamp;
                        w_op_nxt    = i_mode;
                    end
                end else if (i_en) begin
                    w_data_nxt = (i_mode == MODE_LOAD) ? i_d_in : w_step_q;
                end
            end
            ST_RUN: begin
                w_data_nxt = w_step_q;
                w_rem_nxt  = r_rem - CNT_ONE;
                if (r_rem == CNT_ONE) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_d_out    = r_data;
        o_sout_msb = r_data[WIDTH-1];
        o_sout_lsb = r_data[0];
        o_busy     = (r_state == ST_RUN);
        o_done     = r_done;
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus randomized traffic, all compared
// against an arithmetic reference model of the word and burst handshake.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W+1);
    localparam int M  = 1 << W;
    localparam int H  = M / 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_en;
    logic [2:0]    i_mode;
    logic [W-1:0]  i_d_in;
    logic          i_sin_msb;
    logic          i_sin_lsb;
    logic          i_start;
    logic [CW-1:0] i_cnt;
    logic [W-1:0]  o_d_out;
    logic          o_sout_msb;
    logic          o_sout_lsb;
    logic          o_busy;
    logic          o_done;

    univ_shift_reg #(.WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (i_en),
        .i_mode     (i_mode),
        .i_d_in     (i_d_in),
        .i_sin_msb  (i_sin_msb),
        .i_sin_lsb  (i_sin_lsb),
        .i_start    (i_start),
        .i_cnt      (i_cnt),
        .o_d_out    (o_d_out),
        .o_sout_msb (o_sout_msb),
        .o_sout_lsb (o_sout_lsb),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "init";

    int m_val;
    int m_left;
    int m_op;
    bit m_busy;
    bit m_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int step_of(input int op, input int v, input int smsb, input int slsb);
        case (op)
            2:       return (v * 2 + slsb) % M;
            3:       return v / 2 + smsb * H;
            4:       return (v * 2) % M + v / H;
            5:       return v / 2 + (v % 2) * H;
            6:       return v / 2 + ((v >= H) ? H : 0);
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        m_val  = 0;
        m_left = 0;
        m_op   = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        int nv;
        bit nd;
        nv = m_val;
        nd = 1'b0;
        if (m_busy) begin
            nv = step_of(m_op, m_val, int'(i_sin_msb), int'(i_sin_lsb));
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                nd     = 1'b1;
            end
        end else if (i_start && i_mode >= 2 && i_mode <= 6) begin
            if (i_cnt == 0) begin
                nd = 1'b1;
            end else begin
                m_busy = 1'b1;
                m_left = (int'(i_cnt) > W) ? W : int'(i_cnt);
                m_op   = int'(i_mode);
            end
        end else if (i_en) begin
            nv = (i_mode == 3'd1) ? int'(i_d_in) : step_of(int'(i_mode), m_val, int'(i_sin_msb), int'(i_sin_lsb));
        end
        m_val  = nv;
        m_done = nd;
    endtask

    task automatic compare_all();
        chk({phase, "_dout"}, 32'(o_d_out), 32'(m_val));
        chk({phase, "_busy"}, 32'(o_busy), 32'(m_busy));
        chk({phase, "_done"}, 32'(o_done), 32'(m_done));
        chk({phase, "_smsb"}, 32'(o_sout_msb), 32'(m_val / H));
        chk({phase, "_slsb"}, 32'(o_sout_lsb), 32'(m_val % 2));
    endtask

    task automatic cyc(input bit en, input int mode, input int d, input bit smsb,
                       input bit slsb, input bit start, input int cnt);
        i_en      = en;
        i_mode    = 3'(mode);
        i_d_in    = W'(d);
        i_sin_msb = smsb;
        i_sin_lsb = slsb;
        i_start   = start;
        i_cnt     = CW'(cnt);
        @(posedge i_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic load(input int v);
        cyc(1'b1, 1, v, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_en = 1'b0; i_mode = '0; i_d_in = '0; i_sin_msb = 1'b0; i_sin_lsb = 1'b0;
        i_start = 1'b0; i_cnt = '0;
        model_reset();
        #12;
        chk("rst_dout", 32'(o_d_out), 32'h00);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_done", 32'(o_done), 32'h0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        phase = "single";
        load(8'hA5);
        chk("load_a5", 32'(o_d_out), 32'hA5);
        cyc(1'b1, 2, 0, 1'b0, 1'b1, 1'b0, 0);
        chk("shl_4b", 32'(o_d_out), 32'h4B);
        cyc(1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 0);
        chk("ror_a5", 32'(o_d_out), 32'hA5);
        load(8'h80);
        cyc(1'b1, 6, 0, 1'b0, 1'b0, 1'b0, 0);
        chk("asr_c0", 32'(o_d_out), 32'hC0);
        cyc(1'b1, 7, 8'h12, 1'b1, 1'b1, 1'b0, 0);
        chk("rsvd_hold", 32'(o_d_out), 32'hC0);

        phase = "rol3";
        load(8'h81);
        cyc(1'b0, 4, 0, 1'b0, 1'b0, 1'b1, 3);
        chk("rol_accept_busy", 32'(o_busy), 32'h1);
        chk("rol_accept_noshift", 32'(o_d_out), 32'h81);
        idle(); chk("rol_s1", 32'(o_d_out), 32'h03);
        idle(); chk("rol_s2", 32'(o_d_out), 32'h06);
        idle(); chk("rol_s3", 32'(o_d_out), 32'h0C);
        chk("rol_done", 32'(o_done), 32'h1);
        chk("rol_busy_low", 32'(o_busy), 32'h0);
        cyc(1'b0, 4, 0, 1'b0, 1'b0, 1'b1, 2);
        chk("b2b_busy", 32'(o_busy), 32'h1);
        chk("b2b_done_low", 32'(o_done), 32'h0);
        idle(); idle();
        chk("b2b_result", 32'(o_d_out), 32'h30);
        idle();

        phase = "clamp";
        load(8'h00);
        cyc(1'b0, 3, 0, 1'b1, 1'b0, 1'b1, 15);
        for (int i = 0; i < 7; i++) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
        chk("clamp_busy7", 32'(o_busy), 32'h1);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
        chk("clamp_ff", 32'(o_d_out), 32'hFF);
        chk("clamp_done", 32'(o_done), 32'h1);
        idle();

        phase = "cnt0";
        cyc(1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 0);
        chk("cnt0_done", 32'(o_done), 32'h1);
        chk("cnt0_busy", 32'(o_busy), 32'h0);
        chk("cnt0_dout", 32'(o_d_out), 32'hFF);
        idle();
        chk("cnt0_done_once", 32'(o_done), 32'h0);

        phase = "ignore";
        load(8'h5A);
        cyc(1'b0, 4, 0, 1'b0, 1'b0, 1'b1, 4);
        for (int i = 0; i < 4; i++)
            cyc(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
        chk("ignore_a5", 32'(o_d_out), 32'hA5);
        idle();

        phase = "rstmid";
        load(8'h33);
        cyc(1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 5);
        idle();
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("rstmid_dout", 32'(o_d_out), 32'h00);
        chk("rstmid_busy", 32'(o_busy), 32'h0);
        chk("rstmid_done", 32'(o_done), 32'h0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) idle();
        load(8'h96);
        chk("post_rst_load", 32'(o_d_out), 32'h96);
        cyc(1'b0, 5, 0, 1'b0, 1'b0, 1'b1, 2);
        idle(); idle();
        chk("post_rst_burst", 32'(o_d_out), 32'hA5);
        chk("post_rst_done", 32'(o_done), 32'h1);

        phase = "rand";
        for (int i = 0; i < 600; i++) begin
            bit st;
            st = (m_busy) ? 1'($urandom) : ($urandom_range(0, 4) == 0);
            cyc(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                1'($urandom), 1'($urandom), st, int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, the successor to the fixed 4-bit PIPO register. Provides per-cycle hold, parallel load, logical shift, rotate and arithmetic shift of a WIDTH-bit word, with serial in/out at both ends. A burst engine executes an N-step shift/rotate autonomously under a start/busy/done handshake. Used as a datapath building block in serialisers, barrel-shift substitutes and test-pattern generators.

## Interface
- WIDTH, 8: register width, ≥2.
- CW, $clog2(WIDTH+1): width of the burst count input.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  single-step enable, honoured only in IDLE.
- mode  input  3  operation select; encodings listed under Operation.
- d_in  input  WIDTH  parallel load data.
- sin_msb  input  1  serial bit entering the MSB on SHR/ROR-less right shift.
- sin_lsb  input  1  serial bit entering the LSB on SHL.
- start  input  1  burst request, honoured only in IDLE.
- cnt  input  CW  burst step count, sampled with start.
- d_out  output  WIDTH  register contents.
- sout_msb  output  1  d_out[WIDTH-1], combinational.
- sout_lsb  output  1  d_out[0], combinational.
- busy  output  1  burst in progress.
- done  output  1  one-cycle burst completion pulse.

## Operation
- Mode encodings:
  - 000 HOLD
  - 001 LOAD (d_out <= d_in)
  - 010 SHL: {d[W-2:0], sin_lsb}
  - 011 SHR: {sin_msb, d[W-1:1]}
  - 100 ROL
  - 101 ROR
  - 110 ASR: {d[W-1], d[W-1:1]}; sin_msb is ignored.
  - 111 reserved, behaves as HOLD.
- States: IDLE, RUN.
- IDLE, start=1, mode in {SHL, SHR, ROL, ROR, ASR}, cnt≠0:
  - latch the mode into op_q;
  - latch min(cnt, WIDTH) into rem_q;
  - go to RUN. No shift occurs on this edge.
- IDLE, start=1, cnt=0:
  - no register change;
  - done pulses in the next cycle;
  - busy stays 0.
- IDLE, start=1, non-shift mode: start is ignored; the en path applies.
- IDLE, start=0, en=1: one step of the current mode on the edge.
- IDLE, en=0 and start=0: hold.
- start has priority over en.
- RUN:
  - each edge performs one step of op_q and decrements rem_q;
  - the edge with rem_q==1 performs the last step and returns to IDLE.
  - mode, en, start, cnt and d_in are ignored.
  - sin_msb and sin_lsb are sampled live on every step.
- Clamping cnt: a burst of WIDTH rotates restores the word; a burst of WIDTH logical shifts fully replaces it with serial bits.
- Reset (async, any state, including mid-burst):
  - d_out=0, busy=0, done=0;
  - state=IDLE, rem_q=0, op_q=HOLD.
  - The interrupted burst is abandoned with no done pulse.

## Timing
- Single step: d_out updates on the edge where en=1 is sampled (latency 1).
- Burst accepted at edge k with count N:
  - steps occur on edges k+1 … k+N;
  - busy=1 from after edge k until edge k+N;
  - done=1 for exactly the cycle after edge k+N;
  - busy and done are never high together.
- A new start is accepted on the same edge where done is high (back-to-back bursts, zero bubble).
- busy and done are registered. sout_msb and sout_lsb are combinational from d_out.

## Structure
- Package usr_pkg: mode localparams (MODE_HOLD … MODE_ASR) and the state encoding (ST_IDLE, ST_RUN).
- Sub-module usr_step: a combinational next-word function taking (mode, d, sin_msb, sin_lsb). It is shared by the single-step and burst paths.
- Top level holds the FSM, rem_q, op_q and the data register.

## Test plan
- Reset and load, WIDTH=8:
  - rst low → d_out=00, busy=0, done=0.
  - Release reset, LOAD d_in=A5 with en=1 → d_out=A5 after 1 edge.
- Single steps from A5:
  - SHL with sin_lsb=1 → 4B.
  - ROR → A5 restored.
  - ASR on 80 → C0.
  - mode=111 → unchanged.
- Burst ROL, N=3, from 81:
  - busy high for 3 cycles; d_out goes 03, 06, 0C.
  - done pulses once the cycle after; start at that cycle begins a new burst immediately.
- Burst clamping and cnt=0:
  - cnt=15 with SHR and sin_msb=1 on 00 → exactly 8 steps, d_out=FF.
  - cnt=0 → done pulse, no busy, d_out unchanged.
- Reset mid-burst:
  - assert rst during step 2 of a 5-step SHL → immediate d_out=00, busy=0, no done.
  - After release, en/start are accepted normally.
- Ignored inputs during RUN: toggle en, start, mode and d_in throughout a burst → the result matches the latched op only.
